// File: rtl/ddr_arbiter.sv
// Two-port 32-bit requester arbiter in front of a 128-bit DDR controller app interface.
// One transaction in flight; fair alternation when both ports contend.
module ddr_arbiter #(
  parameter int ADDR_W = 28,
  parameter int APP_DW = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_W-1:0]     p0_addr_i,
  input  logic [31:0]           p0_wdata_i,
  input  logic [3:0]            p0_be_i,
  output logic                  p0_ack_o,
  output logic [31:0]           p0_rdata_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_W-1:0]     p1_addr_i,
  input  logic [31:0]           p1_wdata_i,
  input  logic [3:0]            p1_be_i,
  output logic                  p1_ack_o,
  output logic [31:0]           p1_rdata_o,
  input  logic                  calib_done_i,
  output logic [ADDR_W-1:0]     app_addr_o,
  output logic [2:0]            app_cmd_o,
  output logic                  app_en_o,
  input  logic                  app_rdy_i,
  output logic [APP_DW-1:0]     app_wdf_data_o,
  output logic [APP_DW/8-1:0]   app_wdf_mask_o,
  output logic                  app_wdf_wren_o,
  output logic                  app_wdf_end_o,
  input  logic                  app_wdf_rdy_i,
  input  logic [APP_DW-1:0]     app_rd_data_i,
  input  logic                  app_rd_data_valid_i,
  output logic                  busy_o
);

  localparam int DATA_W = 32;
  localparam int LANES  = APP_DW / DATA_W;

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR, ACK} state_t;

  state_t      state;
  logic        gnt_port;
  logic [1:0]  gnt_lane;
  logic        last_grant;
  logic        cmd_done;
  logic        wdf_done;

  logic              any_req;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_be;
  logic              cmd_ok;
  logic              wdf_ok;
  logic              unused_addr_bits;

  function automatic logic [ADDR_W-1:0] app_addr(input logic [ADDR_W-1:0] a);
    return {1'b0, a[ADDR_W-1:4], 3'b000};
  endfunction

  // Only the selected 32-bit lane may be written; every other byte stays masked.
  function automatic logic [APP_DW/8-1:0] wdf_mask(input logic [1:0] lane, input logic [3:0] be);
    logic [APP_DW/8-1:0] m;
    m = '1;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) m[{lane, 2'(n)}] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] lane_word(input logic [APP_DW-1:0] data, input logic [1:0] lane);
    return data[{lane, 5'd0} +: DATA_W];
  endfunction

  assign unused_addr_bits = ^{p0_addr_i[1:0], p1_addr_i[1:0]};

  always_comb begin
    any_req   = p0_req_i | p1_req_i;
    pick      = (p0_req_i & p1_req_i) ? ~last_grant : p1_req_i;
    sel_we    = p0_we_i;
    sel_addr  = p0_addr_i;
    sel_wdata = p0_wdata_i;
    sel_be    = p0_be_i;
    if (pick) begin
      sel_we    = p1_we_i;
      sel_addr  = p1_addr_i;
      sel_wdata = p1_wdata_i;
      sel_be    = p1_be_i;
    end
    cmd_ok = cmd_done | (app_en_o & app_rdy_i);
    wdf_ok = wdf_done | (app_wdf_wren_o & app_wdf_rdy_i);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      gnt_port       <= 1'b0;
      gnt_lane       <= 2'b00;
      last_grant     <= 1'b1;
      cmd_done       <= 1'b0;
      wdf_done       <= 1'b0;
      p0_ack_o       <= 1'b0;
      p1_ack_o       <= 1'b0;
      p0_rdata_o     <= '0;
      p1_rdata_o     <= '0;
      app_addr_o     <= '0;
      app_cmd_o      <= 3'b000;
      app_en_o       <= 1'b0;
      app_wdf_data_o <= '0;
      app_wdf_mask_o <= '0;
      app_wdf_wren_o <= 1'b0;
      app_wdf_end_o  <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (calib_done_i && any_req) begin
            gnt_port   <= pick;
            gnt_lane   <= sel_addr[3:2];
            last_grant <= pick;
            busy_o     <= 1'b1;
            app_addr_o <= app_addr(sel_addr);
            app_en_o   <= 1'b1;
            if (sel_we) begin
              state          <= WR;
              app_cmd_o      <= 3'b000;
              app_wdf_data_o <= {LANES{sel_wdata}};
              app_wdf_mask_o <= wdf_mask(sel_addr[3:2], sel_be);
              app_wdf_wren_o <= 1'b1;
              app_wdf_end_o  <= 1'b1;
            end else begin
              state     <= RD_CMD;
              app_cmd_o <= 3'b001;
            end
          end
        end
        RD_CMD: begin
          if (app_rdy_i) begin
            app_en_o <= 1'b0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (app_rd_data_valid_i) begin
            if (gnt_port) begin
              p1_rdata_o <= lane_word(app_rd_data_i, gnt_lane);
              p1_ack_o   <= 1'b1;
            end else begin
              p0_rdata_o <= lane_word(app_rd_data_i, gnt_lane);
              p0_ack_o   <= 1'b1;
            end
            state <= ACK;
          end
        end
        WR: begin
          // Command and data channels handshake independently; finish when both have.
          if (app_en_o && app_rdy_i) begin
            app_en_o <= 1'b0;
            cmd_done <= 1'b1;
          end
          if (app_wdf_wren_o && app_wdf_rdy_i) begin
            app_wdf_wren_o <= 1'b0;
            app_wdf_end_o  <= 1'b0;
            wdf_done       <= 1'b1;
          end
          if (cmd_ok && wdf_ok) begin
            cmd_done <= 1'b0;
            wdf_done <= 1'b0;
            if (gnt_port) p1_ack_o <= 1'b1;
            else          p0_ack_o <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          p0_ack_o <= 1'b0;
          p1_ack_o <= 1'b0;
          busy_o   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
